// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: RV32I load/store func3 codes
// and the default memory size in bytes.
package data_mem_pkg;

    localparam int DEFAULT_MEM_BYTES = 1024;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes (share encodings with the signed loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_extend.sv
// Load result formatter: takes the raw little-endian 32-bit fetch starting
// at the load address and produces the sign/zero-extended load result.
// Ports:
//   read_en : load enable; result is 0 when low
//   func3   : RV32I load width/sign code
//   raw     : bytes addr..addr+3 packed little-endian
//   result  : extended load value (0 for unsupported codes)
module load_extend
    import data_mem_pkg::*;
(
    input  logic        read_en,
    input  logic [2:0]  func3,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        if (read_en) begin
            case (func3)
                F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
                F3_LBU:  result = {24'h0, raw[7:0]};
                F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
                F3_LHU:  result = {16'h0, raw[15:0]};
                F3_LW:   result = raw;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with RV32I load/store widths.
// Loads are combinational from current contents; stores and the full
// clear-on-reset happen on the rising clock edge. Multi-byte accesses
// wrap around the end of the array and need no alignment.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset, clears every byte
//   MemRead  : load enable
//   MemWrite : store enable
//   func3    : load/store width/sign code
//   addr     : byte address (taken modulo MEM_BYTES)
//   data_in  : store data, low-order bytes used for narrow stores
//   data_out : load result
module data_mem
    import data_mem_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int AW = $clog2(MEM_BYTES);

    // Register array rather than block RAM: the whole array must clear in a
    // single reset edge and reads are combinational.
    logic [7:0]    mem_reg [MEM_BYTES];

    logic [AW-1:0] lane_idx [4];
    logic [31:0]   raw_word;
    logic [3:0]    store_mask;

    // Address bits above the array size are ignored (modulo addressing).
    logic addr_unused;
    assign addr_unused = &{1'b0, addr[31:AW]};

    // Lane gi covers byte addr+gi; AW-bit addition gives the wrap-around.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_idx[gi]          = addr[AW-1:0] + AW'(gi);
            assign raw_word[8*gi +: 8]   = mem_reg[lane_idx[gi]];
        end
    endgenerate

    always_comb begin
        store_mask = 4'b0000;
        if (MemWrite) begin
            case (func3)
                F3_SB:   store_mask = 4'b0001;
                F3_SH:   store_mask = 4'b0011;
                F3_SW:   store_mask = 4'b1111;
                default: store_mask = 4'b0000;
            endcase
        end
    end

    // Reset wins over a concurrent store. Lane indices are distinct because
    // MEM_BYTES >= 8, so no two lanes target the same byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (store_mask[l]) begin
                    mem_reg[lane_idx[l]] <= data_in[8*l +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .read_en (MemRead),
        .func3   (func3),
        .raw     (raw_word),
        .result  (data_out)
    );

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    data_mem #(.MEM_BYTES(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .func3    (func3),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty obs=%h exp=entry", data_out);
            return;
        end
        e = sb_q.pop_front();
        vectors++;
        assert (data_out === e.exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", e.tag, data_out, e.exp);
        end
        $display("vec %0d %s addr=%0d f3=%b data_out=%h exp=%h",
                 vectors, e.tag, addr, func3, data_out, e.exp);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        func3    = f3;
        addr     = a;
        data_in  = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic load(input string tag, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = rd;
        func3    = f3;
        addr     = a;
        expect_out(tag, exp);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        func3 = F3_LW; addr = 32'd0; data_in = 32'h0;
        @(posedge clk);
        #1;
        expect_out("reset_lw0", 32'h0);
        check_out();
        @(negedge clk);
        rst = 1'b0;
        load("reset_lw_top", 1'b1, F3_LW, MB - 4, 32'h0);

        // Sign/zero byte
        store(F3_SW, 0, 32'h000006F4);
        load("lb_neg",  1'b1, F3_LB,  0, 32'hFFFFFFF4);
        load("lbu",     1'b1, F3_LBU, 0, 32'h000000F4);

        // Sign/zero half
        store(F3_SW, 4, 32'h0004E634);
        load("lh_neg",  1'b1, F3_LH,  4, 32'hFFFFE634);
        load("lhu",     1'b1, F3_LHU, 4, 32'h0000E634);

        // Overwrite and word loads
        store(F3_SW, 0, 32'h030106F4);
        load("lw0",     1'b1, F3_LW,  0, 32'h030106F4);
        load("lw4",     1'b1, F3_LW,  4, 32'h0004E634);
        load("lh_pos_unal", 1'b1, F3_LH, 1, 32'h00000106);
        load("lb_pos",  1'b1, F3_LB,  3, 32'h00000003);

        // Narrow stores only take low-order bytes
        store(F3_SW, 8,  32'hFFFFFFFF);
        store(F3_SB, 9,  32'hAAAAAA12);
        store(F3_SH, 10, 32'h5555ABCD);
        load("narrow_lw8", 1'b1, F3_LW, 8, 32'hABCD12FF);

        // Unaligned word across the end of memory
        store(F3_SW, MB - 2, 32'h11223344);
        load("wrap_lhu_top", 1'b1, F3_LHU, MB - 2, 32'h00003344);
        load("wrap_lhu_0",   1'b1, F3_LHU, 0,      32'h00001122);
        load("wrap_lw_top",  1'b1, F3_LW,  MB - 2, 32'h11223344);
        load("wrap_lw0",     1'b1, F3_LW,  0,      32'h03011122);
        load("addr_alias",   1'b1, F3_LW,  MB + 8, 32'hABCD12FF);

        // Control corners
        load("noread_lw",  1'b0, F3_LW,  8, 32'h0);
        load("noread_lbu", 1'b0, F3_LBU, 8, 32'h0);
        load("bad_f3_011", 1'b1, 3'b011, 8, 32'h0);
        load("bad_f3_110", 1'b1, 3'b110, 8, 32'h0);
        load("bad_f3_111", 1'b1, 3'b111, 8, 32'h0);
        store(3'b100, 8, 32'h0);
        store(3'b011, 8, 32'h0);
        store(3'b111, 8, 32'h0);
        load("bad_store_nochg", 1'b1, F3_LW, 8, 32'hABCD12FF);

        // Simultaneous read and write: old contents before edge, new after
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b1; func3 = F3_LW;
        addr = 32'd16; data_in = 32'hDEADBEEF;
        expect_out("rw_pre_edge", 32'h0);
        #1;
        check_out();
        @(posedge clk);
        #1;
        expect_out("rw_post_edge", 32'hDEADBEEF);
        check_out();
        @(negedge clk);
        MemWrite = 1'b0;
        load("rw_next_cycle", 1'b1, F3_LW, 16, 32'hDEADBEEF);

        // One reset edge with a concurrent store: everything reads 0
        @(negedge clk);
        rst = 1'b1; MemWrite = 1'b1; MemRead = 1'b0;
        func3 = F3_SW; addr = 32'd20; data_in = 32'h12345678;
        @(negedge clk);
        rst = 1'b0; MemWrite = 1'b0;
        load("rst_lw0",   1'b1, F3_LW, 0,      32'h0);
        load("rst_lw4",   1'b1, F3_LW, 4,      32'h0);
        load("rst_lw8",   1'b1, F3_LW, 8,      32'h0);
        load("rst_lw16",  1'b1, F3_LW, 16,     32'h0);
        load("rst_wr20",  1'b1, F3_LW, 20,     32'h0);
        load("rst_lwtop", 1'b1, F3_LW, MB - 2, 32'h0);

        // Stores resume after reset
        store(F3_SB, 5, 32'h00000080);
        load("post_rst_lb", 1'b1, F3_LB, 5, 32'hFFFFFF80);
        load("post_rst_lw", 1'b1, F3_LW, 4, 32'h00008000);

        if (sb_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover obs=%0d exp=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
